seg_scanner: RTL and testbench
==============================

SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 Parameter ScanDiv, default 16: width of the refresh divider; each digit is held for 2^ScanDiv clk cycles.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ld  input  1  one-cycle load request; samples val.
REQ-005 val  input  32  binary value to display, typically a counter output.
REQ-006 busy  output  1  conversion in progress; ld is ignored while high.
REQ-007 ovf  output  1  decimal value exceeds 8 digits.
REQ-008 an  output  8  digit enables, active-low, one-hot-zero.
REQ-009 seg  output  8  segments, active-low; seg[6:0]=g..a, seg[7]=dp.

Function
REQ-010 ld SHALL be accepted only in a cycle where busy=0; ld with busy=1 SHALL have no effect.
REQ-011 With SEG_BCD_EN defined, accepting ld SHALL latch val and start a shift-add-3 binary-to-BCD conversion into a 40-bit (10-digit) BCD register, one bit per cycle.
REQ-012 busy SHALL be 1 for exactly 32 cycles, starting the cycle after ld is accepted.
REQ-013 On the last conversion cycle, the low 8 BCD digits SHALL load into the display register atomically, and ovf SHALL become 1 if either of the upper 2 BCD digits is nonzero, else 0.
REQ-014 The display register and ovf SHALL keep their previous values throughout a conversion.
REQ-015 A ld coincident with the final conversion cycle SHALL be ignored, because busy=1 in that cycle.
REQ-016 A free-running ScanDiv-bit divider SHALL increment every cycle.
  - The digit index (0..7) SHALL advance when the divider is all-ones.
  - The index SHALL wrap from 7 to 0.
REQ-017 an[i] SHALL be 0 only for i = current index; digit 0 is the least significant.
REQ-018 seg[6:0] SHALL be the active-low decode of the selected display nibble.
  - Hex glyphs 0-F (A,b,C,d,E,F).
  - '0'=7'h40, '8'=7'h00, 'd'=7'h21.
REQ-019 seg[7] SHALL be 0 (dp lit) on every digit while ovf=1, else 1.
REQ-020 an and seg SHALL be registered, and SHALL change only on clk edges or reset.

Reset
REQ-021 While rst=1, the following SHALL hold:
  - divider=0, index=0, display register=0, BCD state cleared;
  - busy=0, ovf=0;
  - an=8'hFE, seg=8'hC0.
REQ-022 rst asserted mid-conversion SHALL abort the conversion immediately; no partial result SHALL reach the display.
REQ-023 After rst deasserts, the first cycle SHALL accept ld.

Configuration
REQ-024 Macro SEG_BCD_EN selects the display mode.
REQ-025 With SEG_BCD_EN defined: decimal display per REQ-011..REQ-015.
REQ-026 Without SEG_BCD_EN:
  - No converter SHALL be built.
  - An accepted ld SHALL load the 8 hex nibbles of val into the display register on the next edge.
  - busy and ovf SHALL be constant 0.

Verification
REQ-027 Bench SHALL use ScanDiv=2 and cover the following scenarios:
REQ-028 Reset: assert rst mid-cycle -> an=FE, seg=C0, busy=0, ovf=0 without waiting for a clk edge.
REQ-029 BCD: ld val=32'd12345678 -> busy=1 for 32 cycles, ovf=0.
  - Scanning then shows digits 8,7,6,5,4,3,2,1 for indices 0..7.
  - Index 0 shows seg=8'h80.
REQ-030 BCD overflow: ld val=32'hFFFFFFFF -> ovf=1; digits 0..7 = 5,9,2,7,6,9,4,9; seg[7]=0 on every digit.
REQ-031 Busy ignore:
  - ld 32'd5, then ld 32'd99 on the 10th busy cycle.
  - Display shows 5; busy drops exactly 32 cycles after the first ld.
REQ-032 Abort: ld 32'd42, rst pulse on the 10th busy cycle -> busy=0 at once; display stays all '0'; a new ld of 32'd7 then completes normally.
REQ-033 Hex build (SEG_BCD_EN undefined): ld val=32'h0000ABCD -> next cycle the display register holds ABCD.
  - Index 0 shows seg=8'hA1.
  - busy remains 0 throughout.

Source files
------------

// File: rtl/seg_scanner.sv
// seg_scanner: 8-digit multiplexed seven-segment driver.
// Optional macro SEG_BCD_EN: when defined, a loaded value is converted to
// decimal (shift-add-3, one bit per cycle) before display; otherwise the
// eight hex nibbles of the loaded value are shown directly.
// an/seg are registered from the next-cycle state so they always match the
// digit index and display contents held in the same cycle.
module seg_scanner #(
    parameter int ScanDiv = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [31:0] val,
    output logic        busy,
    output logic        ovf,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam logic [ScanDiv-1:0] DivOne = {{(ScanDiv-1){1'b0}}, 1'b1};

    // Active-low g..a pattern for one hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [ScanDiv-1:0] div_r;
    logic [2:0]         idx_r;
    logic [2:0]         idx_next_s;
    logic [31:0]        disp_r;
    logic [31:0]        disp_next_s;
    logic               ovf_next_s;
    logic               ld_ok_s;

`ifdef SEG_BCD_EN
    // Add 3 to every BCD digit that is 5 or more, ahead of the shift.
    function automatic logic [39:0] add3_all(input logic [39:0] b);
        logic [39:0] r;
        for (int k = 0; k < 10; k++) begin
            r[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? (b[4*k +: 4] + 4'd3) : b[4*k +: 4];
        end
        return r;
    endfunction

    logic [31:0] bin_r;
    logic [39:0] bcd_r;
    logic [4:0]  cnt_r;
    logic        busy_r;
    logic        ovf_r;
    logic [39:0] adj_s;
    logic [39:0] shl_s;
    logic        last_s;

    assign ld_ok_s = ld & ~busy_r;
    assign busy    = busy_r;
    assign ovf     = ovf_r;

    // One shift-add-3 step; the result is committed only on the last step.
    always_comb begin
        adj_s       = add3_all(bcd_r);
        shl_s       = {adj_s[38:0], bin_r[31]};
        last_s      = busy_r & (cnt_r == 5'd31);
        if (last_s) begin
            disp_next_s = shl_s[31:0];
            // A carry out of the top digit cannot happen for 32-bit input,
            // but would still mean the value did not fit.
            ovf_next_s  = (|shl_s[39:32]) | adj_s[39];
        end else begin
            disp_next_s = disp_r;
            ovf_next_s  = ovf_r;
        end
    end

    // Converter sequencing: latch on accepted ld, then 32 shift steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r  <= 32'h0;
            bcd_r  <= 40'h0;
            cnt_r  <= 5'd0;
            busy_r <= 1'b0;
        end else if (ld_ok_s) begin
            bin_r  <= val;
            bcd_r  <= 40'h0;
            cnt_r  <= 5'd0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            bin_r  <= {bin_r[30:0], 1'b0};
            bcd_r  <= shl_s;
            cnt_r  <= cnt_r + 5'd1;
            busy_r <= (cnt_r != 5'd31);
        end else begin
            bin_r  <= bin_r;
            bcd_r  <= bcd_r;
            cnt_r  <= cnt_r;
            busy_r <= busy_r;
        end
    end

    // Overflow flag follows the committed conversion result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_next_s;
        end
    end
`else
    assign ld_ok_s = ld;
    assign busy    = 1'b0;
    assign ovf     = 1'b0;

    // Hex mode: an accepted ld loads the raw nibbles directly.
    always_comb begin
        ovf_next_s = 1'b0;
        if (ld_ok_s) begin
            disp_next_s = val;
        end else begin
            disp_next_s = disp_r;
        end
    end
`endif

    // Digit index steps when the refresh divider is about to wrap.
    always_comb begin
        if (&div_r) begin
            idx_next_s = idx_r + 3'd1;
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Divider, index, display register and registered digit outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r  <= {ScanDiv{1'b0}};
            idx_r  <= 3'd0;
            disp_r <= 32'h0;
            an     <= 8'hFE;
            seg    <= 8'hC0;
        end else begin
            div_r  <= div_r + DivOne;
            idx_r  <= idx_next_s;
            disp_r <= disp_next_s;
            an     <= ~(8'h01 << idx_next_s);
            seg    <= {~ovf_next_s, glyph(disp_next_s[{idx_next_s, 2'b00} +: 4])};
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
// Self-checking bench for seg_scanner (ScanDiv=2). Expected display contents
// are pushed to a scoreboard queue when ld is driven and popped when the
// result should be visible. Follows SEG_BCD_EN the same way as the design.
module tb_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic [31:0] val;
    logic        busy;
    logic        ovf;
    logic [7:0]  an;
    logic [7:0]  seg;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] digits;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    logic last_ovf = 1'b0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scanner #(.ScanDiv(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .val  (val),
        .busy (busy),
        .ovf  (ovf),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected display for a loaded value.
    function automatic exp_t model(input logic [31:0] v);
        exp_t   e;
        longint x;
        x = longint'(v);
`ifdef SEG_BCD_EN
        for (int k = 0; k < 8; k++) begin
            e.digits[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        e.ovf = (x != 0);
`else
        e.digits = v;
        e.ovf    = 1'b0;
`endif
        return e;
    endfunction

    task automatic rst_check(input string tag);
        check_eq({tag, "_an"},   {24'h0, an},   32'hFE);
        check_eq({tag, "_seg"},  {24'h0, seg},  32'hC0);
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check_eq({tag, "_ovf"},  {31'h0, ovf},  32'h0);
    endtask

    // Walk the scan through indices 0..7 and compare each digit's pattern.
    task automatic scan_check(input logic [31:0] d, input logic o, input string tag);
        logic [7:0] exp_an;
        logic [3:0] nib;
        int w;
        for (int i = 0; i < 8; i++) begin
            exp_an = ~(8'h01 << i);
            w = 0;
            while (an !== exp_an && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (w >= 40) begin
                check_eq({tag, "_an_timeout"}, {24'h0, an}, {24'h0, exp_an});
            end else begin
                nib = d[4*i +: 4];
                check_eq({tag, "_seg"}, {24'h0, seg}, {24'h0, ~o, glyph_tab[nib]});
            end
        end
    endtask

`ifdef SEG_BCD_EN
    // Load v; optionally re-request ld (value inj_val) on busy cycles inj_a/inj_b.
    task automatic do_conv(input logic [31:0] v, input int inj_a, input int inj_b,
                           input logic [31:0] inj_val, input string tag);
        exp_t e;
        int   n;
        e = model(v);
        sb_q.push_back(e);
        ld  = 1'b1;
        val = v;
        @(negedge clk);
        ld = 1'b0;
        n  = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 10) check_eq({tag, "_hold_ovf"}, {31'h0, ovf}, {31'h0, last_ovf});
            if (n == inj_a || n == inj_b) begin
                ld  = 1'b1;
                val = inj_val;
            end
            @(negedge clk);
            ld = 1'b0;
        end
        check_eq({tag, "_busy_len"}, n, 32);
        @(negedge clk);
        check_eq({tag, "_busy_idle"}, {31'h0, busy}, 32'h0);
        e = sb_q.pop_front();
        check_eq({tag, "_ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
        last_ovf = e.ovf;
        scan_check(e.digits, e.ovf, tag);
    endtask
`else
    // Load v in hex mode; the new nibbles must be visible the next cycle.
    task automatic hex_load(input logic [31:0] v, input string tag);
        exp_t e;
        int   cur;
        logic [3:0] nib;
        e = model(v);
        sb_q.push_back(e);
        ld  = 1'b1;
        val = v;
        @(negedge clk);
        ld = 1'b0;
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'h0);
        e = sb_q.pop_front();
        cur = 0;
        for (int i = 0; i < 8; i++) begin
            if (an === ~(8'h01 << i)) cur = i;
        end
        nib = e.digits[4*cur +: 4];
        check_eq({tag, "_next"}, {24'h0, seg}, {24'h0, 1'b1, glyph_tab[nib]});
        check_eq({tag, "_ovf"}, {31'h0, ovf}, 32'h0);
        scan_check(e.digits, e.ovf, tag);
        check_eq({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        ld  = 1'b0;
        val = 32'h0;
        repeat (2) @(negedge clk);
        rst_check("reset");
        rst = 1'b0;

`ifdef SEG_BCD_EN
        do_conv(32'd12345678, 0, 0, 32'h0, "bcd_main");
        do_conv(32'hFFFFFFFF, 0, 0, 32'h0, "bcd_ovf");
        do_conv(32'd5, 10, 32, 32'd99, "bcd_ignore");

        // Abort a conversion with a reset pulse in the middle of busy cycle 10.
        ld  = 1'b1;
        val = 32'd42;
        @(negedge clk);
        ld = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("abort_busy_pre", {31'h0, busy}, 32'h1);
        #2 rst = 1'b1;
        #1 rst_check("abort");
        @(negedge clk);
        rst = 1'b0;
        last_ovf = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("abort_busy_post", {31'h0, busy}, 32'h0);
        scan_check(32'h0, 1'b0, "abort_disp");

        // ld in the very first cycle after reset release must be accepted.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_conv(32'd7, 0, 0, 32'h0, "bcd_after_rst");
`else
        hex_load(32'h0000ABCD, "hex_abcd");
        hex_load(32'h89EF0123, "hex_mix");
        hex_load(32'hFFFFFFFF, "hex_ones");
        #2 rst = 1'b1;
        #1 rst_check("abort");
        @(negedge clk);
        rst = 1'b0;
        scan_check(32'h0, 1'b0, "abort_disp");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hex_load(32'h13572468, "hex_after_rst");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
